rf_scoreboard: RTL and testbench
================================

RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data bits per register.
REQ-002 SHALL have parameter DEPTH, default 8, number of registers (2..256, need not be a power of two).
REQ-003 SHALL have parameter ZERO_R0, default 0; when 1, register 0 reads as zero and ignores writes and reservations.
REQ-004 SHALL derive AW = max(1, ceil(log2(DEPTH))) for all select widths.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-007 read1regsel  input  AW  port-1 read select.
REQ-008 read2regsel  input  AW  port-2 read select.
REQ-009 read1data  output  WIDTH  port-1 read data (combinational).
REQ-010 read2data  output  WIDTH  port-2 read data (combinational).
REQ-011 read1busy  output  1  port-1 selected register has a pending reservation.
REQ-012 read2busy  output  1  port-2 selected register has a pending reservation.
REQ-013 writeregsel  input  AW  write destination.
REQ-014 writedata  input  WIDTH  write data.
REQ-015 write  input  1  write enable.
REQ-016 resv  input  1  reserve request: marks a destination busy.
REQ-017 resvsel  input  AW  register to reserve.
REQ-018 err  output  1  sticky error flag, registered.

Function
REQ-019 Write: when write=1 and writeregsel<DEPTH, register[writeregsel] SHALL take writedata at the clock edge; 1-cycle write latency.
REQ-020 Read: readNdata SHALL equal register[readNregsel] combinationally, 0-cycle latency.
REQ-021 Bypass: when write=1 and writeregsel==readNregsel (valid, not zero-R0), readNdata SHALL equal writedata in the same cycle.
REQ-022 Scoreboard: one busy bit per register; resv=1 with valid resvsel SHALL set busy[resvsel] at the edge.
REQ-023 A valid write SHALL clear busy[writeregsel] at the edge.
REQ-024 Same-edge resv and write to the same register: data written, busy stays set (reservation wins).
REQ-025 readNbusy SHALL equal busy[readNregsel] AND NOT (write and writeregsel==readNregsel); i.e. a completing write is visible as not-busy in the same cycle.
REQ-026 ZERO_R0=1: select 0 SHALL read data 0, busy 0; writes/reservations to register 0 SHALL have no effect and no error.
REQ-027 Out-of-range select (>=DEPTH) on a read port SHALL return data 0, busy 0.
REQ-028 Out-of-range write or reservation SHALL be ignored (no state change).
REQ-029 err SHALL set at the next edge on any of: out-of-range select on an active port (reads always active; write/resv when enabled); resv to a register already busy and not being written that cycle (WAW); write to a register not busy when any reservation exists is NOT an error.
REQ-030 err SHALL remain 1 until reset.

Reset
REQ-031 rst=0 at an edge SHALL clear all registers to 0, all busy bits to 0, err to 0; write/resv in that cycle ignored.
REQ-032 After reset, read1data=read2data=0, read1busy=read2busy=0, err=0.
REQ-033 Reset mid-operation SHALL discard pending reservations with no error.

Structure
REQ-034 A shared package SHALL hold the AW derivation function and the default WIDTH/DEPTH constants.
REQ-035 One sub-module, rf_read_port (select, array, busy vector, write-bypass inputs -> data, busy, range-error), SHALL be instantiated once per read port.
REQ-036 Storage and busy vector SHALL be flat arrays; no latches; single always block per sequential state group.

Verification
REQ-037 Reset, write R3=0x1234, read R3 next cycle on both ports -> 0x1234, busy 0, err 0.
REQ-038 resv R5; next cycle read1 R5 -> busy 1; write R5=0xBEEF same cycle -> read1data 0xBEEF, read1busy 0; following cycle busy 0.
REQ-039 Same edge resv R2 and write R2=0x00AA -> R2 reads 0x00AA, busy 1.
REQ-040 resv R4 twice without intervening write -> err 1 after second edge, stays 1 until rst=0.
REQ-041 DEPTH=6: read1regsel=7 -> read1data 0, err 1 next edge; write to 6 leaves all registers unchanged.
REQ-042 ZERO_R0=1: write R0=0xFFFF, resv R0 -> R0 reads 0, busy 0, err 0.

Source files
------------

// File: rtl/rf_scoreboard_pkg.sv
// rtl/rf_scoreboard_pkg.sv - shared constants and select-width helper for the register scoreboard
package rf_scoreboard_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 8;

   // Select width never drops below one bit, even for a two-entry file.
   function automatic int calc_aw(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// rtl/rf_scoreboard_if.sv - read/write/reserve bus of the register scoreboard
interface rf_scoreboard_if
   import rf_scoreboard_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int AW    = calc_aw(DEF_DEPTH)
);
   logic [AW-1:0]    read1regsel;
   logic [AW-1:0]    read2regsel;
   logic [WIDTH-1:0] read1data;
   logic [WIDTH-1:0] read2data;
   logic             read1busy;
   logic             read2busy;
   logic [AW-1:0]    writeregsel;
   logic [WIDTH-1:0] writedata;
   logic             write;
   logic             resv;
   logic [AW-1:0]    resvsel;
   logic             err;

   modport master (
      output read1regsel, read2regsel, writeregsel, writedata, write, resv, resvsel,
      input  read1data, read2data, read1busy, read2busy, err
   );

   modport slave (
      input  read1regsel, read2regsel, writeregsel, writedata, write, resv, resvsel,
      output read1data, read2data, read1busy, read2busy, err
   );

endinterface

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one combinational read port with write bypass and range check
module rf_read_port
   import rf_scoreboard_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int AW      = calc_aw(DEF_DEPTH),
   parameter int ZERO_R0 = 0
) (
   input  logic [AW-1:0]    i_sel,
   input  logic [WIDTH-1:0] i_regs [DEPTH],
   input  logic [DEPTH-1:0] i_busy,
   input  logic             i_wr_valid,
   input  logic [AW-1:0]    i_wr_sel,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic [WIDTH-1:0] o_data,
   output logic             o_busy,
   output logic             o_range_err
);
   logic w_inr;
   logic w_zero;

   assign w_inr       = int'(i_sel) < DEPTH;
   assign w_zero      = (ZERO_R0 != 0) && (i_sel == '0);
   assign o_range_err = !w_inr;

   // i_wr_valid already excludes out-of-range and hard-zero destinations.
   always_comb begin
      o_data = '0;
      o_busy = 1'b0;
      if (w_inr && !w_zero) begin
         if (i_wr_valid && (i_wr_sel == i_sel)) begin
            o_data = i_wr_data;
         end else begin
            o_data = i_regs[i_sel];
            o_busy = i_busy[i_sel];
         end
      end
   end

endmodule

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - register file with per-register reservation bits and sticky error flag
module rf_scoreboard
   import rf_scoreboard_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int ZERO_R0 = 0
) (
   input logic            clk,
   input logic            rst,
   rf_scoreboard_if.slave bus
);
   localparam int AW = calc_aw(DEPTH);

   logic [WIDTH-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0] r_busy;
   logic             r_err;

   logic          w_wr_inr;
   logic          w_wr_valid;
   logic [AW-1:0] w_wr_idx;
   logic          w_rs_inr;
   logic          w_rs_valid;
   logic [AW-1:0] w_rs_idx;
   logic          w_waw;
   logic          w_rd1_rerr;
   logic          w_rd2_rerr;
   logic          w_err_set;

   assign w_wr_inr   = int'(bus.writeregsel) < DEPTH;
   assign w_wr_valid = bus.write && w_wr_inr && !((ZERO_R0 != 0) && (bus.writeregsel == '0));
   assign w_wr_idx   = w_wr_inr ? bus.writeregsel : '0;

   assign w_rs_inr   = int'(bus.resvsel) < DEPTH;
   assign w_rs_valid = bus.resv && w_rs_inr && !((ZERO_R0 != 0) && (bus.resvsel == '0));
   assign w_rs_idx   = w_rs_inr ? bus.resvsel : '0;

   // Re-reserving is only legal when the current reservation retires on this same edge.
   assign w_waw = w_rs_valid && r_busy[w_rs_idx]
                  && !(w_wr_valid && (bus.writeregsel == bus.resvsel));

   assign w_err_set = w_rd1_rerr || w_rd2_rerr
                      || (bus.write && !w_wr_inr)
                      || (bus.resv && !w_rs_inr)
                      || w_waw;

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      end else if (w_wr_valid) begin
         r_regs[w_wr_idx] <= bus.writedata;
      end
   end

   // Set follows clear so a same-edge reservation beats the retiring write.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_busy <= '0;
      end else begin
         if (w_wr_valid) r_busy[w_wr_idx] <= 1'b0;
         if (w_rs_valid) r_busy[w_rs_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_err <= 1'b0;
      end else if (w_err_set) begin
         r_err <= 1'b1;
      end
   end

   assign bus.err = r_err;

   rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_R0(ZERO_R0)) u_rd1 (
      .i_sel       (bus.read1regsel),
      .i_regs      (r_regs),
      .i_busy      (r_busy),
      .i_wr_valid  (w_wr_valid),
      .i_wr_sel    (bus.writeregsel),
      .i_wr_data   (bus.writedata),
      .o_data      (bus.read1data),
      .o_busy      (bus.read1busy),
      .o_range_err (w_rd1_rerr)
   );

   rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .ZERO_R0(ZERO_R0)) u_rd2 (
      .i_sel       (bus.read2regsel),
      .i_regs      (r_regs),
      .i_busy      (r_busy),
      .i_wr_valid  (w_wr_valid),
      .i_wr_sel    (bus.writeregsel),
      .i_wr_data   (bus.writedata),
      .o_data      (bus.read2data),
      .o_busy      (bus.read2busy),
      .o_range_err (w_rd2_rerr)
   );

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb/tb_rf_scoreboard.sv - directed and randomized self-checking bench for rf_scoreboard
module tb_rf_scoreboard;
   import rf_scoreboard_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   rf_scoreboard_if #(.WIDTH(16), .AW(3)) ia ();
   rf_scoreboard_if #(.WIDTH(16), .AW(3)) ib ();

   rf_scoreboard #(.WIDTH(16), .DEPTH(8), .ZERO_R0(0)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   rf_scoreboard #(.WIDTH(16), .DEPTH(6), .ZERO_R0(1)) dut_b (.clk(clk), .rst(rst), .bus(ib));

   int checks   = 0;
   int failures = 0;

   logic [15:0] m_regs [8];
   bit          m_busy [8];
   bit          m_err;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      ia.write = 1'b0; ia.resv = 1'b0; ia.writeregsel = '0; ia.writedata = '0; ia.resvsel = '0;
   endtask

   task automatic idle_b();
      ib.write = 1'b0; ib.resv = 1'b0; ib.writeregsel = '0; ib.writedata = '0; ib.resvsel = '0;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      m_err = 1'b0;
   endtask

   initial begin
      bit          do_rst;
      logic [15:0] e1, e2;
      bit          b1, b2;

      idle_a(); ia.read1regsel = '0; ia.read2regsel = 3'd3;
      idle_b(); ib.read1regsel = '0; ib.read2regsel = '0;
      rst = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      chk("reset_rd1data", ia.read1data, 0);
      chk("reset_rd2data", ia.read2data, 0);
      chk("reset_busy", {ia.read1busy, ia.read2busy}, 0);
      chk("reset_err", ia.err, 0);

      // write R3, then read it on both ports
      ia.write = 1'b1; ia.writeregsel = 3'd3; ia.writedata = 16'h1234;
      tick(); idle_a();
      ia.read1regsel = 3'd3; ia.read2regsel = 3'd3;
      #1;
      chk("r3_rd1data", ia.read1data, 16'h1234);
      chk("r3_rd2data", ia.read2data, 16'h1234);
      chk("r3_busy", {ia.read1busy, ia.read2busy}, 0);
      chk("r3_err", ia.err, 0);

      // reserve R5, complete it with a bypassed write
      ia.resv = 1'b1; ia.resvsel = 3'd5;
      tick(); idle_a();
      ia.read1regsel = 3'd5;
      #1;
      chk("r5_busy_set", ia.read1busy, 1);
      ia.write = 1'b1; ia.writeregsel = 3'd5; ia.writedata = 16'hBEEF;
      #1;
      chk("r5_bypass_data", ia.read1data, 16'hBEEF);
      chk("r5_bypass_busy", ia.read1busy, 0);
      tick(); idle_a();
      #1;
      chk("r5_after_busy", ia.read1busy, 0);
      chk("r5_after_data", ia.read1data, 16'hBEEF);

      // same-edge reserve and write: data lands, reservation remains
      ia.resv = 1'b1; ia.resvsel = 3'd2;
      ia.write = 1'b1; ia.writeregsel = 3'd2; ia.writedata = 16'h00AA;
      tick(); idle_a();
      ia.read1regsel = 3'd2;
      #1;
      chk("r2_data", ia.read1data, 16'h00AA);
      chk("r2_busy", ia.read1busy, 1);
      chk("r2_err", ia.err, 0);

      // double reservation of R4 is a WAW error, sticky until reset
      ia.resv = 1'b1; ia.resvsel = 3'd4;
      tick();
      chk("waw_first_err", ia.err, 0);
      tick(); idle_a();
      chk("waw_second_err", ia.err, 1);
      tick(); tick();
      chk("waw_sticky_err", ia.err, 1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      ia.read1regsel = 3'd2; ia.read2regsel = 3'd3;
      #1;
      chk("rst_err_clear", ia.err, 0);
      chk("rst_r2_busy_clear", ia.read1busy, 0);
      chk("rst_r3_data_clear", ia.read2data, 0);

      // randomized traffic against the reference model
      model_reset();
      for (int n = 0; n < 600; n++) begin
         do_rst = ($urandom_range(0, 49) == 0);
         rst = !do_rst;
         ia.write       = 1'($urandom_range(0, 1));
         ia.writeregsel = 3'($urandom_range(0, 7));
         ia.writedata   = 16'($urandom);
         ia.resv        = ($urandom_range(0, 3) == 0);
         ia.resvsel     = 3'($urandom_range(0, 7));
         ia.read1regsel = 3'($urandom_range(0, 7));
         ia.read2regsel = ($urandom_range(0, 2) == 0) ? ia.writeregsel : 3'($urandom_range(0, 7));
         #1;
         if (ia.write && ia.writeregsel == ia.read1regsel) begin
            e1 = ia.writedata; b1 = 1'b0;
         end else begin
            e1 = m_regs[ia.read1regsel]; b1 = m_busy[ia.read1regsel];
         end
         if (ia.write && ia.writeregsel == ia.read2regsel) begin
            e2 = ia.writedata; b2 = 1'b0;
         end else begin
            e2 = m_regs[ia.read2regsel]; b2 = m_busy[ia.read2regsel];
         end
         chk("rand_rd1data", ia.read1data, e1);
         chk("rand_rd2data", ia.read2data, e2);
         chk("rand_rd1busy", ia.read1busy, b1);
         chk("rand_rd2busy", ia.read2busy, b2);
         chk("rand_err", ia.err, m_err);
         if (do_rst) begin
            model_reset();
         end else begin
            if (ia.resv && m_busy[ia.resvsel] && !(ia.write && ia.writeregsel == ia.resvsel))
               m_err = 1'b1;
            if (ia.write) begin
               m_regs[ia.writeregsel] = ia.writedata;
               m_busy[ia.writeregsel] = 1'b0;
            end
            if (ia.resv) m_busy[ia.resvsel] = 1'b1;
         end
         tick();
      end
      rst = 1'b1;
      idle_a();

      // hard-zero R0 on the six-entry instance
      rst = 1'b0;
      tick();
      rst = 1'b1;
      ib.write = 1'b1; ib.writeregsel = '0; ib.writedata = 16'hFFFF;
      ib.resv  = 1'b1; ib.resvsel = '0;
      #1;
      chk("z0_bypass_data", ib.read1data, 0);
      tick(); idle_b();
      #1;
      chk("z0_data", ib.read1data, 0);
      chk("z0_busy", ib.read1busy, 0);
      chk("z0_err", ib.err, 0);

      for (int i = 1; i < 6; i++) begin
         ib.write = 1'b1; ib.writeregsel = 3'(i); ib.writedata = 16'(16'h1000 + i);
         tick();
      end
      // out-of-range write to 6 must not alias any register
      ib.write = 1'b1; ib.writeregsel = 3'd6; ib.writedata = 16'hFFFF;
      ib.read1regsel = 3'd5;
      #1;
      chk("oor_wr_no_bypass", ib.read1data, 16'h1005);
      tick(); idle_b();
      chk("oor_wr_err", ib.err, 1);
      for (int i = 1; i < 6; i++) begin
         ib.read1regsel = 3'(i);
         #1;
         chk("oor_wr_regs_kept", ib.read1data, 32'(16'h1000 + i));
      end
      ib.read1regsel = '0;
      ib.read2regsel = 3'd6;
      #1;
      chk("oor_rd_data6", ib.read2data, 0);
      chk("oor_rd_busy6", ib.read2busy, 0);

      ib.read2regsel = '0;
      rst = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("oor_rst_err", ib.err, 0);
      ib.read1regsel = 3'd7;
      #1;
      chk("oor_rd_data7", ib.read1data, 0);
      tick();
      chk("oor_rd_err", ib.err, 1);
      ib.read1regsel = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
